// File: rtl/fsk_rx_framer_pkg.sv
// fsk_rx_pkg: shared state type, codeword type and default constants for the FSK receive framer
package fsk_rx_pkg;
  localparam int CODE_W = 14;
  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA7;
  typedef enum logic {HUNT, RECV} state_t;
  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/fsk_rx_framer_if.sv
// fsk_rx_framer_if: valid/ready codeword stream from the framer to the Hamming decoder
interface fsk_rx_framer_if import fsk_rx_pkg::*; #(parameter int W = CODE_W);
  logic [W-1:0] code_data;
  logic code_valid;
  logic code_ready;
  modport master (output code_data, code_valid, input code_ready);
  modport slave (input code_data, code_valid, output code_ready);
endinterface

// File: rtl/fsk_rx_framer_fifo2.sv
// fsk_rx_fifo2: 2-entry first-word-fall-through buffer; a push into a full buffer is
// accepted only when a pop frees the head slot in the same cycle
module fsk_rx_fifo2 import fsk_rx_pkg::*; #(parameter int W = CODE_W) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, wr;
  logic [1:0] cnt;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign wr = push && (!full || pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (wr) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr ^ wr;
      rd_ptr <= rd_ptr ^ pop;
      cnt <= cnt + {1'b0, wr} - {1'b0, pop};
    end
endmodule

// File: rtl/fsk_rx_framer.sv
// fsk_rx_framer: hunts for the sync word, frames FRAME_WORDS codewords into a 2-entry
// buffer, and drops lock when the bit strobes stall for TIMEOUT cycles
module fsk_rx_framer import fsk_rx_pkg::*; #(
  parameter int CODE_W = fsk_rx_pkg::CODE_W,
  parameter int SYNC_W = fsk_rx_pkg::SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = fsk_rx_pkg::SYNC_WORD,
  parameter int FRAME_WORDS = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic bit_stb,
  input  logic bit_val,
  fsk_rx_framer_if.master code,
  output logic locked,
  output logic frame_done,
  output logic overflow,
  output logic [7:0] drop_cnt,
  input  logic clr_status
);
  localparam int BW = $clog2(CODE_W);
  localparam int IW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [SYNC_W-2:0] sync_sr;
  logic [CODE_W-2:0] word_sr;
  logic [SYNC_W-1:0] sync_nxt;
  logic [CODE_W-1:0] word_nxt, head;
  logic [BW-1:0] bit_cnt;
  logic [7:0] word_cnt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic stb, match, word_done, frame_end, timeout, pop, full, empty, drop;
  assign stb = enable && bit_stb;
  assign sync_nxt = {sync_sr, bit_val};
  assign word_nxt = {word_sr, bit_val};
  // idle counter saturates so a long silence in HUNT cannot wrap into a false timeout
  assign idle_nxt = stb ? '0 : idle_cnt == IW'(TIMEOUT) ? idle_cnt : idle_cnt + 1'b1;
  assign match = state == HUNT && stb && sync_nxt == SYNC_WORD;
  assign word_done = state == RECV && stb && bit_cnt == BW'(CODE_W - 1);
  assign frame_end = word_done && word_cnt == 8'(FRAME_WORDS - 1);
  assign timeout = state == RECV && idle_nxt == IW'(TIMEOUT);
  assign pop = !empty && code.code_ready;
  assign drop = word_done && full && !pop;
  assign code.code_valid = !empty;
  assign code.code_data = head;
  fsk_rx_fifo2 #(.W(CODE_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(word_done),
    .pop(pop),
    .din(word_nxt),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= HUNT;
    else state <= state_nxt;
  always_comb
    state_nxt = !enable ? HUNT : state == HUNT ? (match ? RECV : HUNT) : (frame_end || timeout ? HUNT : RECV);
  always_comb locked = state == RECV;
  // sync history and counters are held clear outside the state that uses them,
  // so each entry into HUNT or RECV starts from zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync_sr <= '0;
      word_sr <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
      idle_cnt <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      sync_sr <= state == HUNT && enable ? (stb ? sync_nxt[SYNC_W-2:0] : sync_sr) : '0;
      word_sr <= state == RECV && stb ? word_nxt[CODE_W-2:0] : word_sr;
      bit_cnt <= state != RECV || word_done ? '0 : stb ? bit_cnt + 1'b1 : bit_cnt;
      word_cnt <= state != RECV ? '0 : word_cnt + 8'(word_done);
      idle_cnt <= idle_nxt;
      frame_done <= frame_end;
      overflow <= drop || (overflow && !clr_status);
      drop_cnt <= drop ? (clr_status ? 8'd1 : drop_cnt + 8'(drop_cnt != 8'hFF)) : clr_status ? 8'd0 : drop_cnt;
    end
endmodule

// File: tb/tb_fsk_rx_framer.sv
// tb_fsk_rx_framer: directed scenarios plus randomized traffic against a bit-history /
// queue reference model of the framer
module tb_fsk_rx_framer;
  import fsk_rx_pkg::*;
  localparam int FW = 3;
  localparam int TO = 20;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, bit_stb = 1'b0, bit_val = 1'b0, clr_status = 1'b0;
  logic locked, frame_done, overflow;
  logic [7:0] drop_cnt;
  int n_cmp = 0, n_bad = 0;
  int m_hist, m_word, m_bits, m_words, m_gap, m_drops;
  bit m_lock, m_fd, m_ovf;
  code_t m_q[$];

  fsk_rx_framer_if bus ();
  fsk_rx_framer #(.FRAME_WORDS(FW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bit_stb(bit_stb), .bit_val(bit_val),
    .code(bus.master), .locked(locked), .frame_done(frame_done), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_status(clr_status)
  );
  always #5 clk = ~clk;

  task automatic model_clear();
    m_lock = 0; m_fd = 0; m_ovf = 0; m_hist = 0; m_word = 0; m_bits = 0;
    m_words = 0; m_gap = 0; m_drops = 0; m_q.delete();
  endtask

  // one clock edge of the receiver, described as bit history, bit counts and a queue
  task automatic model_step();
    bit s, pushed, dropped;
    if (!reset) begin model_clear(); return; end
    s = enable && bit_stb;
    pushed = 0;
    m_fd = 0;
    m_gap = s ? 0 : m_gap + 1;
    if (m_q.size() > 0 && bus.code_ready) void'(m_q.pop_front());
    if (!enable) begin m_lock = 0; m_hist = 0; end
    else if (!m_lock) begin
      if (s) m_hist = (m_hist * 2 + int'(bit_val)) % 256;
      if (s && m_hist == 'hA7) begin m_lock = 1; m_hist = 0; m_bits = 0; m_words = 0; end
    end else if (s) begin
      m_word = (m_word * 2 + int'(bit_val)) % (1 << 14);
      m_bits++;
      if (m_bits == 14) begin
        pushed = 1; m_bits = 0; m_words++;
        if (m_words == FW) begin m_fd = 1; m_lock = 0; end
      end
    end else if (m_gap == TO) m_lock = 0;
    dropped = pushed && m_q.size() >= 2;
    if (pushed && !dropped) m_q.push_back(code_t'(m_word));
    if (dropped) begin m_ovf = 1; m_drops = clr_status ? 1 : (m_drops < 255 ? m_drops + 1 : 255); end
    else if (clr_status) begin m_ovf = 0; m_drops = 0; end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input logic s, input logic v);
    bit_stb = s; bit_val = v;
    tick();
    bit_stb = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, w[i]);
  endtask

  task automatic idle_hunt();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    model_clear();
    #20;
    n_cmp++; if ({locked, bus.code_valid, frame_done, overflow} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b exp 0000", {locked, bus.code_valid, frame_done, overflow}); end
    n_cmp++; if (bus.code_data !== 14'h0 || drop_cnt !== 8'h0) begin n_bad++; $display("FAIL reset_values data=%h drop=%0d exp 0/0", bus.code_data, drop_cnt); end
    @(posedge clk); #1 reset = 1'b1;
    enable = 1'b1;
    tick();
    n_cmp++; if ({locked, bus.code_valid} !== 2'b0) begin n_bad++; $display("FAIL reset_release got %b exp 00", {locked, bus.code_valid}); end
  endtask

  task automatic test_sync_deliver();
    idle_hunt();
    bus.code_ready = 1'b1;
    send(32'h53, 7);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL sync_partial locked=%b exp 0", locked); end
    step(1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sync_lock locked=%b exp 1", locked); end
    send(32'h0D2E, 13);
    n_cmp++; if (bus.code_valid !== 1'b0) begin n_bad++; $display("FAIL deliver_early valid=%b exp 0", bus.code_valid); end
    step(1'b1, 1'b0);
    n_cmp++; if (bus.code_valid !== 1'b1 || bus.code_data !== 14'h1A5C) begin n_bad++; $display("FAIL deliver_word valid=%b data=%h exp 1/1a5c", bus.code_valid, bus.code_data); end
    tick();
    n_cmp++; if (bus.code_valid !== 1'b0) begin n_bad++; $display("FAIL deliver_pop valid=%b exp 0", bus.code_valid); end
    idle_hunt();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL enable_low locked=%b exp 0", locked); end
  endtask

  task automatic test_false_sync();
    logic [21:0] pat = {8'hA6, 14'h2AAA};
    idle_hunt();
    for (int i = 21; i >= 0; i--) begin
      step(1'b1, pat[i]);
      n_cmp++; if ({locked, bus.code_valid} !== 2'b0) begin n_bad++; $display("FAIL false_sync bit %0d got %b exp 00", i, {locked, bus.code_valid}); end
    end
  endtask

  task automatic test_frame_end();
    logic [13:0] w [4] = '{14'h0001, 14'h3FFF, 14'h1234, 14'h0ABC};
    int fd = 0;
    idle_hunt();
    bus.code_ready = 1'b1;
    send(32'hA7, 8);
    for (int k = 0; k < 4; k++) begin
      for (int i = 13; i >= 0; i--) begin
        step(1'b1, w[k][i]);
        fd += int'(frame_done);
      end
      if (k < 3) begin
        n_cmp++; if (bus.code_valid !== 1'b1 || bus.code_data !== w[k]) begin n_bad++; $display("FAIL frame_word%0d valid=%b data=%h exp 1/%h", k, bus.code_valid, bus.code_data, w[k]); end
      end else begin
        n_cmp++; if (bus.code_valid !== 1'b0) begin n_bad++; $display("FAIL frame_ignored valid=%b exp 0", bus.code_valid); end
      end
      if (k == 2) begin
        n_cmp++; if (locked !== 1'b0 || frame_done !== 1'b1) begin n_bad++; $display("FAIL frame_end locked=%b done=%b exp 0/1", locked, frame_done); end
      end
    end
    n_cmp++; if (fd !== 1) begin n_bad++; $display("FAIL frame_done_count got %0d exp 1", fd); end
  endtask

  task automatic test_backpressure();
    idle_hunt();
    bus.code_ready = 1'b0;
    send(32'hA7, 8);
    send(32'h2001, 14);
    send(32'h0F0F, 14);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_no_ovf overflow=%b exp 0", overflow); end
    send(32'h1555, 14);
    n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin n_bad++; $display("FAIL bp_drop ovf=%b drop=%0d exp 1/1", overflow, drop_cnt); end
    n_cmp++; if (bus.code_valid !== 1'b1 || bus.code_data !== 14'h2001) begin n_bad++; $display("FAIL bp_head valid=%b data=%h exp 1/2001", bus.code_valid, bus.code_data); end
    send(32'hA7, 8);
    send(32'h0123, 14);
    n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL bp_drop2 drop=%0d exp 2", drop_cnt); end
    send(32'h0246, 13);
    clr_status = 1'b1;
    step(1'b1, 1'b1);
    clr_status = 1'b0;
    n_cmp++; if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin n_bad++; $display("FAIL bp_clr_vs_drop ovf=%b drop=%0d exp 1/1", overflow, drop_cnt); end
    send(32'h3333, 14);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_bad++; $display("FAIL bp_clear ovf=%b drop=%0d exp 0/0", overflow, drop_cnt); end
    bus.code_ready = 1'b1;
    n_cmp++; if (bus.code_data !== 14'h2001) begin n_bad++; $display("FAIL bp_order0 data=%h exp 2001", bus.code_data); end
    tick();
    n_cmp++; if (bus.code_valid !== 1'b1 || bus.code_data !== 14'h0F0F) begin n_bad++; $display("FAIL bp_order1 valid=%b data=%h exp 1/0f0f", bus.code_valid, bus.code_data); end
    tick();
    n_cmp++; if (bus.code_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained valid=%b exp 0", bus.code_valid); end
  endtask

  task automatic test_watchdog();
    int n = 0;
    idle_hunt();
    bus.code_ready = 1'b1;
    send(32'hA7, 8);
    send(32'h16, 5);
    while (locked === 1'b1 && n < 2 * TO) begin tick(); n++; end
    n_cmp++; if (n !== TO) begin n_bad++; $display("FAIL wd_timeout idle cycles to unlock got %0d exp %0d", n, TO); end
    n_cmp++; if (bus.code_valid !== 1'b0) begin n_bad++; $display("FAIL wd_no_word valid=%b exp 0", bus.code_valid); end
    send(32'hA7, 8);
    send(32'h5, 3);
    for (int i = 0; i < TO - 1; i++) tick();
    step(1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL wd_boundary_strobe locked=%b exp 1", locked); end
    n = 0;
    while (locked === 1'b1 && n < 2 * TO) begin tick(); n++; end
    n_cmp++; if (n !== TO) begin n_bad++; $display("FAIL wd_timeout2 got %0d exp %0d", n, TO); end
    send(32'hA7, 8);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL wd_relock locked=%b exp 1", locked); end
  endtask

  task automatic test_reset_midframe();
    idle_hunt();
    bus.code_ready = 1'b0;
    send(32'hA7, 8);
    send(32'h2ABC, 14);
    send(32'h55, 7);
    n_cmp++; if (bus.code_valid !== 1'b1 || locked !== 1'b1) begin n_bad++; $display("FAIL rst_pre valid=%b locked=%b exp 1/1", bus.code_valid, locked); end
    #2 reset = 1'b0;
    model_clear();
    #1;
    n_cmp++; if ({locked, bus.code_valid, frame_done, overflow, drop_cnt, bus.code_data} !== 26'h0) begin n_bad++; $display("FAIL rst_async locked=%b valid=%b data=%h exp all 0", locked, bus.code_valid, bus.code_data); end
    @(posedge clk); #1 reset = 1'b1;
    tick();
    n_cmp++; if ({locked, bus.code_valid} !== 2'b0) begin n_bad++; $display("FAIL rst_empty got %b exp 00", {locked, bus.code_valid}); end
  endtask

  task automatic test_random();
    int gap = 0, si = 8;
    logic [7:0] sw = 8'hA7;
    idle_hunt();
    for (int c = 0; c < 6000; c++) begin
      enable = $urandom_range(0, 199) != 0;
      bus.code_ready = $urandom_range(0, 99) < (((c / 400) % 2) ? 15 : 85);
      clr_status = $urandom_range(0, 99) == 0;
      if (gap > 0) begin bit_stb = 1'b0; gap--; end
      else begin
        bit_stb = $urandom_range(0, 3) != 0;
        if (si == 8 && $urandom_range(0, 39) == 0) si = 0;
        bit_val = si < 8 ? sw[7 - si] : 1'($urandom_range(0, 1));
        if (bit_stb && si < 8) si++;
        if ($urandom_range(0, 59) == 0) gap = $urandom_range(TO - 3, TO + 3);
      end
      tick();
      n_cmp++; if ({locked, bus.code_valid, frame_done, overflow, drop_cnt} !== {m_lock, m_q.size() > 0, m_fd, m_ovf, 8'(m_drops)}) begin n_bad++; $display("FAIL rand_status cyc %0d got l%b v%b f%b o%b d%0d exp l%b v%b f%b o%b d%0d", c, locked, bus.code_valid, frame_done, overflow, drop_cnt, m_lock, m_q.size() > 0, m_fd, m_ovf, m_drops); end
      if (m_q.size() > 0) begin
        n_cmp++; if (bus.code_data !== m_q[0]) begin n_bad++; $display("FAIL rand_data cyc %0d got %h exp %h", c, bus.code_data, m_q[0]); end
      end
    end
    enable = 1'b1; bit_stb = 1'b0; clr_status = 1'b0;
  endtask

  initial begin
    bus.code_ready = 1'b0;
    test_reset();
    test_sync_deliver();
    test_false_sync();
    test_frame_end();
    test_backpressure();
    test_watchdog();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fsk_rx_framer.md
# fsk_rx_framer

Receive-side controller between the FSK bit slicer and the Hamming decoder. It hunts for a sync word in the recovered serial bit stream and then frames a fixed number of 14-bit Hamming codewords. Completed codewords are delivered to the decoder through a 2-entry valid/ready buffer. A watchdog drops lock when the bit stream stalls.

## Interface
Parameters:
- CODE_W, 14, codeword width in bits
- SYNC_W, 8, sync word width in bits
- SYNC_WORD, 8'hA7, sync pattern, MSB received first
- FRAME_WORDS, 16, codewords per frame, range 1..255
- TIMEOUT, 1023, maximum `clk` cycles allowed between bit strobes while locked

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous reset, active-low
- enable  in  1  receiver enable
- bit_stb  in  1  one-cycle strobe marking a recovered bit
- bit_val  in  1  recovered bit value, qualified by bit_stb
- code_data  out  CODE_W  codeword at the buffer head
- code_valid  out  1  buffer not empty
- code_ready  in  1  consumer accepts code_data
- locked  out  1  high while in RECV
- frame_done  out  1  one-cycle pulse when the last word of a frame is framed
- overflow  out  1  sticky; a word was dropped because the buffer was full
- drop_cnt  out  8  dropped-word count, saturates at 255
- clr_status  in  1  clears overflow and drop_cnt

## Operation
- States: HUNT and RECV. Reset and entry into HUNT clear the sync shift register, bit_cnt and word_cnt.
- HUNT: each bit_stb shifts bit_val into the LSB of the sync register. If the shifted value equals SYNC_WORD, go to RECV. The bit that completes the sync is not part of any codeword.
- RECV: each bit_stb shifts bit_val into the word register, MSB first, and increments bit_cnt.
  - On the CODE_W-th bit: push the assembled word to the buffer, set bit_cnt to 0 and increment word_cnt.
  - If word_cnt reaches FRAME_WORDS: pulse frame_done and go to HUNT.
- Watchdog: the idle counter clears on every bit_stb and counts cycles otherwise. In RECV, when it reaches TIMEOUT, go to HUNT and discard the partial word. A timeout does not change drop_cnt.
- enable low: the block is forced to HUNT and bit_stb is ignored. The buffer keeps draining.
- Buffer: 2 entries, first-word fall-through.
  - code_valid is high when the buffer is not empty. A word pops when code_valid and code_ready are both high.
  - A push into a full buffer is dropped: set overflow and increment drop_cnt.
  - If the buffer is full and a pop happens in the same cycle as a push, the push is accepted and nothing is dropped.
- Status: if clr_status and a drop occur in the same cycle, the drop wins (overflow = 1, drop_cnt = 1).

## Timing
- Reset values: code_data = 0, code_valid = 0, locked = 0, frame_done = 0, overflow = 0, drop_cnt = 0. State is HUNT and the buffer is empty.
- Reset assertion takes effect immediately (asynchronous) and aborts any frame in progress. Release is synchronous to `clk`.
- Sync match on the bit_stb in cycle N: locked = 1 from cycle N+1.
- CODE_W-th bit strobe in cycle N with the buffer empty: code_valid = 1 and code_data valid at cycle N+1.
- frame_done pulses in cycle N+1. locked falls in the same cycle N+1.
- Timeout: with the last strobe in cycle N, locked falls at cycle N+TIMEOUT+1.
- bit_stb arriving in the same cycle as the timeout is counted as a bit and no timeout occurs.
- bit_stb is at most one per cycle. Back-to-back strobes must be handled.

## Structure
- Package fsk_rx_pkg holds:
  - the state enum {HUNT, RECV};
  - default constants CODE_W = 14, SYNC_W = 8, SYNC_WORD = 8'hA7;
  - a codeword typedef logic [CODE_W-1:0].
- Sub-module fsk_rx_fifo2 implements the 2-entry FWFT buffer with push, pop, full and empty. The top level contains the FSM, counters and watchdog.

## Test plan
- Sync and deliver: bits of 8'hA7, then 14'h1A5C MSB first, with code_ready = 1 → code_data = 14'h1A5C and code_valid high for 1 cycle at N+1.
- False sync: bits of 8'hA6, then 14 bits → locked stays 0 and code_valid never rises.
- Frame end (FRAME_WORDS = 2): sync, 14'h0001, 14'h3FFF, 14'h1234 → two words delivered in order, frame_done pulses once, locked = 0 after the second word, and the third word is ignored.
- Backpressure: code_ready = 0, sync, three words → the first two are held in order, overflow = 1, drop_cnt = 1. clr_status then gives overflow = 0 and drop_cnt = 0.
- Watchdog (TIMEOUT = 20): sync, 5 bits, then silence → locked falls 21 cycles after the last strobe and no word is output. Sending the sync again relocks.
- Reset mid-frame: assert reset after 7 bits of a word while 1 word is buffered → all outputs go to 0 immediately and the buffer is empty after release.
